// File: rtl/mips_fifoarb.sv
// rtl/mips_fifoarb.sv - round-robin FIFO write-port arbiter with locked bursts and forced release
// Optional per-requester ack counters: define MIPS_FIFOARB_STATS_EN.
module mips_fifoarb #(
    parameter int S_WORD       = 8,
    parameter int S_ID         = 2,
    parameter int LOCK_TIMEOUT = 15,
    localparam int N           = 1 << S_ID
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req,
    input  logic [N*S_WORD-1:0]    req_data,
    input  logic [N-1:0]           req_last,
    output logic [N-1:0]           ack,
    input  logic                   fifo_full,
    output logic                   fifo_wr_en,
    output logic [S_ID+S_WORD-1:0] fifo_wr_data,
`ifdef MIPS_FIFOARB_STATS_EN
    input  logic [S_ID-1:0]        stat_sel,
    output logic [15:0]            stat_cnt,
`endif
    output logic                   locked,
    output logic [S_ID-1:0]        owner
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [7:0] TMO_MAX = 8'(LOCK_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [S_ID-1:0] rr_ptr_q, rr_ptr_d;
    logic [S_ID-1:0] owner_q, owner_d;
    logic [7:0]      idle_cnt_q, idle_cnt_d;

    logic            sel_valid;
    logic [S_ID-1:0] sel_id;
    logic [S_ID-1:0] scan_idx;
    logic            xfer;

    // Scan from the highest offset down so the closest requester to rr_ptr wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_id    = rr_ptr_q;
        scan_idx  = rr_ptr_q;
        if (state_q == ST_LOCKED) begin
            sel_id    = owner_q;
            sel_valid = req[owner_q];
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                scan_idx = rr_ptr_q + S_ID'(k);
                if (req[scan_idx]) begin
                    sel_valid = 1'b1;
                    sel_id    = scan_idx;
                end
            end
        end
    end

    assign xfer         = sel_valid && !fifo_full && !rst;
    assign fifo_wr_en   = xfer;
    assign fifo_wr_data = {sel_id, req_data[sel_id*S_WORD +: S_WORD]};
    assign locked       = (state_q == ST_LOCKED) && !rst;
    assign owner        = owner_q;

    always_comb begin
        ack = '0;
        if (xfer) begin
            ack[sel_id] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        idle_cnt_d = idle_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    owner_d = sel_id;
                    if (req_last[sel_id]) begin
                        rr_ptr_d = sel_id + 1'b1;
                    end else begin
                        idle_cnt_d = '0;
                        state_d    = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (xfer) begin
                    idle_cnt_d = '0;
                    if (req_last[owner_q]) begin
                        rr_ptr_d = owner_q + 1'b1;
                        state_d  = ST_IDLE;
                    end
                end else if (idle_cnt_q == TMO_MAX) begin
                    rr_ptr_d   = owner_q + 1'b1;
                    idle_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

`ifdef MIPS_FIFOARB_STATS_EN
    logic [15:0] stat_q [N];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (ack[i] && stat_q[i] != 16'hFFFF) begin
                    stat_q[i] <= stat_q[i] + 16'd1;
                end
            end
        end
    end

    assign stat_cnt = stat_q[stat_sel];
`endif

endmodule

// File: tb/tb_mips_fifoarb.sv
// tb/tb_mips_fifoarb.sv - directed self-checking bench for mips_fifoarb (LOCK_TIMEOUT=4)
module tb_mips_fifoarb;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  ack;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [9:0]  fifo_wr_data;
    logic        locked;
    logic [1:0]  owner;
`ifdef MIPS_FIFOARB_STATS_EN
    logic [1:0]  stat_sel;
    logic [15:0] stat_cnt;
`endif

    int n_total = 0;
    int n_bad   = 0;

    mips_fifoarb #(
        .S_WORD      (8),
        .S_ID        (2),
        .LOCK_TIMEOUT(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .req_last    (req_last),
        .ack         (ack),
        .fifo_full   (fifo_full),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
`ifdef MIPS_FIFOARB_STATS_EN
        .stat_sel    (stat_sel),
        .stat_cnt    (stat_cnt),
`endif
        .locked      (locked),
        .owner       (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Sample at negedge (combinational outputs settled), then advance past the next posedge.
    task automatic cyc_check(input string tag, input logic [3:0] exp_ack, input logic [9:0] exp_data,
                             input logic exp_locked);
        @(negedge clk);
        check({tag, ".ack"}, 32'(ack), 32'(exp_ack));
        check({tag, ".wr_en"}, 32'(fifo_wr_en), 32'(exp_ack != 4'b0));
        if (exp_ack != 4'b0) check({tag, ".data"}, 32'(fifo_wr_data), 32'(exp_data));
        check({tag, ".locked"}, 32'(locked), 32'(exp_locked));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        req_data  = '0;
        req_last  = '0;
        fifo_full = 1'b0;
`ifdef MIPS_FIFOARB_STATS_EN
        stat_sel  = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        req      = 4'b1111;
        req_last = 4'b1111;
        cyc_check("reset", 4'b0000, 10'h0, 1'b0);
        rst = 1'b0;
        check("reset.owner", 32'(owner), 32'd0);

        // 1: full rotation
        req_data = 32'h44332211;
        cyc_check("rr0", 4'b0001, {2'd0, 8'h11}, 1'b0);
        cyc_check("rr1", 4'b0010, {2'd1, 8'h22}, 1'b0);
        cyc_check("rr2", 4'b0100, {2'd2, 8'h33}, 1'b0);
        cyc_check("rr3", 4'b1000, {2'd3, 8'h44}, 1'b0);

        // bring rr_ptr to 2
        req = 4'b0010;
        cyc_check("pre2", 4'b0010, {2'd1, 8'h22}, 1'b0);

        // 2: locked burst from ID2 while ID0 waits
        req      = 4'b0101;
        req_last = 4'b0001;
        req_data = 32'h001100A0;
        cyc_check("burst1", 4'b0100, {2'd2, 8'h11}, 1'b0);
        req_data = 32'h002200A0;
        cyc_check("burst2", 4'b0100, {2'd2, 8'h22}, 1'b1);
        check("burst.owner", 32'(owner), 32'd2);
        req_data = 32'h003300A0;
        req_last = 4'b0101;
        cyc_check("burst3", 4'b0100, {2'd2, 8'h33}, 1'b1);
        req = 4'b0001;
        cyc_check("after_burst", 4'b0001, {2'd0, 8'hA0}, 1'b0);

        // bring rr_ptr to 0
        req      = 4'b1000;
        req_last = 4'b1111;
        req_data = 32'hD0C0B0A0;
        cyc_check("pre0", 4'b1000, {2'd3, 8'hD0}, 1'b0);

        // 3: fifo_full blocks everything
        req       = 4'b0101;
        fifo_full = 1'b1;
        cyc_check("full", 4'b0000, 10'h0, 1'b0);
        cyc_check("full2", 4'b0000, 10'h0, 1'b0);
        fifo_full = 1'b0;
        cyc_check("unfull", 4'b0001, {2'd0, 8'hA0}, 1'b0);

        // 4: owner 1 stalls, ID3 ignored, forced release on the 4th idle cycle
        req      = 4'b0010;
        req_last = 4'b0000;
        cyc_check("lock1", 4'b0010, {2'd1, 8'hB0}, 1'b0);
        req      = 4'b1000;
        req_last = 4'b1000;
        for (int i = 0; i < 4; i++) cyc_check($sformatf("stall%0d", i), 4'b0000, 10'h0, 1'b1);
        check("stall.owner", 32'(owner), 32'd1);
        cyc_check("released", 4'b1000, {2'd3, 8'hD0}, 1'b0);

        // 5: reset during a locked burst of ID3
        req_last = 4'b0000;
        cyc_check("lock3", 4'b1000, {2'd3, 8'hD0}, 1'b0);
        check("lock3.locked", 32'(locked), 32'd1);
        rst      = 1'b1;
        req      = 4'b1001;
        cyc_check("rst_mid", 4'b0000, 10'h0, 1'b0);
        rst      = 1'b0;
        req_last = 4'b1001;
        cyc_check("post_rst", 4'b0001, {2'd0, 8'hA0}, 1'b0);

`ifdef MIPS_FIFOARB_STATS_EN
        // 6: saturating ack counters
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        req      = 4'b0001;
        req_last = 4'b0001;
        repeat (70000) @(posedge clk);
        #1;
        req = '0;
        stat_sel = 2'd0;
        #1;
        check("stat0", 32'(stat_cnt), 32'hFFFF);
        stat_sel = 2'd1;
        #1;
        check("stat1", 32'(stat_cnt), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
